// File: rtl/rr_merge_pkg.sv
// Shared helpers for the rr_merge round-robin merge block.
// The packet-lock feature (RR_MERGE_LOCK_EN) uses eot_pos() to find the end-of-packet bit.
package rr_merge_pkg;

  function automatic int idx_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // The end-of-packet flag is always the MSB of an input data word.
  function automatic int eot_pos(input int din_w);
    return din_w - 1;
  endfunction

endpackage

// File: rtl/dti.sv
// Data-transfer interface: a single valid/ready stream of W-bit words.
// A beat moves when valid and ready are both high at a rising clk edge; the producer
// raises valid without waiting for ready and holds valid and data stable until that beat moves.
interface dti #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter holding the priority pointer and, with RR_MERGE_LOCK_EN, the packet lock.
// advance marks a granted transfer; lock_hold on that transfer keeps the grant on the same input.
module rr_arb
  import rr_merge_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int IDX_W = idx_width(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  req,
  input  logic             advance,
  input  logic             lock_hold,
  output logic [SIZE-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_any;

  // Lowest requester at or above ptr wins; otherwise the lowest requester overall (wrap).
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hi_idx = IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
    rr_idx = hi_any ? hi_idx : lo_idx;
  end

`ifdef RR_MERGE_LOCK_EN
  logic             locked;
  logic [IDX_W-1:0] lock_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (advance) begin
      locked <= lock_hold;
      if (lock_hold) lock_idx <= gnt_idx;
    end
  end

  assign gnt_idx = locked ? lock_idx : rr_idx;
`else
  assign gnt_idx = rr_idx;
`endif

  always_comb begin
    gnt = '0;
    for (int i = 0; i < SIZE; i++) begin
      gnt[i] = req[i] && (gnt_idx == IDX_W'(i));
    end
  end

  // The pointer only moves when the granted input is released (every beat without the lock).
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && !lock_hold) begin
      ptr <= (gnt_idx == IDX_W'(SIZE - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_merge.sv
// Round-robin merge of SIZE dti streams into one registered stream tagged {idx, data}.
// Define RR_MERGE_LOCK_EN to hold the grant on one input until a beat with its MSB (eot) set.
module rr_merge
  import rr_merge_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int DIN_W = 16
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  din [SIZE-1:0],
  dti.producer  dout
);

  localparam int IDX_W = idx_width(SIZE);

  logic [SIZE-1:0]        req;
  logic [SIZE-1:0]        gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic [DIN_W-1:0]       din_data [SIZE];
  logic [DIN_W-1:0]       sel_data;
  logic                   load;
  logic                   advance;
  logic                   lock_hold;
  logic                   ob_valid;
  logic [IDX_W+DIN_W-1:0] ob_data;

  // The register accepts a new beat whenever it is empty or its beat leaves this cycle.
  assign load    = !rst && (!ob_valid || dout.ready);
  assign advance = load && (|gnt);

  for (genvar i = 0; i < SIZE; i++) begin : g_in
    assign req[i]      = din[i].valid;
    assign din_data[i] = din[i].data;
    assign din[i].ready = load && gnt[i];
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (gnt[i]) sel_data = sel_data | din_data[i];
    end
  end

`ifdef RR_MERGE_LOCK_EN
  localparam int EOT_POS = eot_pos(DIN_W);
  assign lock_hold = !sel_data[EOT_POS];
`else
  assign lock_hold = 1'b0;
`endif

  rr_arb #(.SIZE(SIZE)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (advance),
    .lock_hold (lock_hold),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ob_valid <= 1'b0;
      ob_data  <= '0;
    end else if (load) begin
      ob_valid <= |gnt;
      if (|gnt) ob_data <= {gnt_idx, sel_data};
    end
  end

  assign dout.valid = ob_valid;
  assign dout.data  = ob_data;

endmodule

// File: tb/tb_rr_merge.sv
// Directed bench for rr_merge: SIZE=3 ordering/backpressure/reset, SIZE=1 stream, SIZE=2 packet lock.
// Expected lock-test order depends on whether RR_MERGE_LOCK_EN is defined.
module tb_rr_merge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef RR_MERGE_LOCK_EN
  localparam logic [15:0] EOT = 16'h8000;
`else
  localparam logic [15:0] EOT = 16'h0000;
`endif

  // DUT A: SIZE=3, DIN_W=16
  dti #(.W(16)) a_in [2:0] ();
  dti #(.W(18)) a_out ();
  logic        a_valid [3];
  logic [15:0] a_data  [3];
  logic [2:0]  a_ready;
  logic        a_dready;
  for (genvar i = 0; i < 3; i++) begin : g_a
    assign a_in[i].valid = a_valid[i];
    assign a_in[i].data  = a_data[i];
    assign a_ready[i]    = a_in[i].ready;
  end
  assign a_out.ready = a_dready;
  rr_merge #(.SIZE(3), .DIN_W(16)) dut_a (.clk(clk), .rst(rst), .din(a_in), .dout(a_out));

  // DUT B: SIZE=1, DIN_W=8
  dti #(.W(8)) b_in [0:0] ();
  dti #(.W(9)) b_out ();
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       b_dready;
  assign b_in[0].valid = b_valid;
  assign b_in[0].data  = b_data;
  assign b_ready       = b_in[0].ready;
  assign b_out.ready   = b_dready;
  rr_merge #(.SIZE(1), .DIN_W(8)) dut_b (.clk(clk), .rst(rst), .din(b_in), .dout(b_out));

  // DUT C: SIZE=2, DIN_W=16
  dti #(.W(16)) c_in [1:0] ();
  dti #(.W(17)) c_out ();
  logic        c_valid [2];
  logic [15:0] c_data  [2];
  logic [1:0]  c_ready;
  logic        c_dready;
  for (genvar i = 0; i < 2; i++) begin : g_c
    assign c_in[i].valid = c_valid[i];
    assign c_in[i].data  = c_data[i];
    assign c_ready[i]    = c_in[i].ready;
  end
  assign c_out.ready = c_dready;
  rr_merge #(.SIZE(2), .DIN_W(16)) dut_c (.clk(clk), .rst(rst), .din(c_in), .dout(c_out));

  logic [8:0]  exp_q [$];
  logic [16:0] rec_q [$];
  logic [16:0] exp6  [5];
  logic [15:0] pkt   [3];

  initial begin
    int   sent;
    int   got;
    int   p0;
    logic fire;
    logic fire0;
    logic gap;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin a_valid[i] = 1'b0; a_data[i] = '0; end
    for (int i = 0; i < 2; i++) begin c_valid[i] = 1'b0; c_data[i] = '0; end
    b_valid = 1'b0; b_data = '0;
    a_dready = 1'b1; b_dready = 1'b1; c_dready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_a_valid", a_out.valid, 0);
    check("rst_a_ptr", dut_a.u_arb.ptr, 0);
    check("rst_b_valid", b_out.valid, 0);
    check("rst_c_valid", c_out.valid, 0);

    // Test 1: all inputs valid, ready high
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin a_valid[i] = 1'b1; a_data[i] = EOT | 16'(16 + i); end
    #1;
    check("t1_first_latency", a_out.valid, 0);
    check("t1_first_ready", a_ready, 3'b001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("t1_valid", a_out.valid, 1);
      check("t1_beat", a_out.data, {2'(k % 3), EOT | 16'(16 + k % 3)});
    end

    // Test 2: only input 2 valid while ptr is 0
    a_valid[0] = 1'b0; a_valid[1] = 1'b0;
    a_data[2] = 16'hABCD;
    #1;
    check("t2_ptr_before", dut_a.u_arb.ptr, 0);
    check("t2_ready", a_ready, 3'b100);
    @(negedge clk); #1;
    check("t2_valid", a_out.valid, 1);
    check("t2_beat", a_out.data, 18'h2ABCD);
    check("t2_ptr_after", dut_a.u_arb.ptr, 0);
    a_valid[2] = 1'b0;
    @(negedge clk); #1;
    check("t2_drain", a_out.valid, 0);

    // Test 3: backpressure for 4 cycles with a held beat
    a_dready = 1'b0;
    for (int i = 0; i < 3; i++) begin a_valid[i] = 1'b1; a_data[i] = EOT | 16'(32 + i); end
    @(negedge clk); #1;
    check("t3_load", a_out.data, {2'd0, EOT | 16'h0020});
    check("t3_ptr_load", dut_a.u_arb.ptr, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("t3_hold_data", a_out.data, {2'd0, EOT | 16'h0020});
      check("t3_hold_ready", a_ready, 3'b000);
      check("t3_hold_ptr", dut_a.u_arb.ptr, 1);
    end
    a_dready = 1'b1;
    #1;
    check("t3_release_ready", a_ready, 3'b010);
    @(negedge clk); #1;
    check("t3_refill", a_out.data, {2'd1, EOT | 16'h0021});
    check("t3_refill_valid", a_out.valid, 1);
    check("t3_ptr_refill", dut_a.u_arb.ptr, 2);

    // Test 4: reset while holding an idx-1 beat
    a_dready = 1'b0;
    rst = 1'b1;
    #1;
    check("t4_rst_ready", a_ready, 3'b000);
    @(negedge clk); #1;
    check("t4_valid", a_out.valid, 0);
    check("t4_ptr", dut_a.u_arb.ptr, 0);
    rst = 1'b0;
    a_dready = 1'b1;
    @(negedge clk); #1;
    check("t4_first_valid", a_out.valid, 1);
    check("t4_first_beat", a_out.data, {2'd0, EOT | 16'h0020});
    for (int i = 0; i < 3; i++) a_valid[i] = 1'b0;

    // Test 5: SIZE=1 stream with random output ready
    sent = 0; got = 0; fire = 1'b0;
    for (int cyc = 0; cyc < 80 && !(sent == 5 && exp_q.size() == 0); cyc++) begin
      @(negedge clk);
      if (fire) sent++;
      b_valid  = (sent < 5);
      b_data   = 8'(sent + 1);
      b_dready = ($urandom_range(0, 3) != 0);
      #1;
      fire = b_valid & b_ready;
      if (b_out.valid && b_dready) begin
        if (exp_q.size() == 0) begin
          check("t5_spurious_beat_qsize", exp_q.size(), 1);
        end else begin
          check("t5_beat", b_out.data, exp_q.pop_front());
          got++;
        end
      end
      if (fire) exp_q.push_back({1'b0, b_data});
    end
    b_valid = 1'b0;
    b_dready = 1'b1;
    check("t5_sent", sent, 5);
    check("t5_received", got, 5);

    // Test 6: 3-beat packet on input 0 with a gap, input 1 always valid
    pkt[0] = 16'h0001; pkt[1] = 16'h0002; pkt[2] = 16'h8003;
`ifdef RR_MERGE_LOCK_EN
    exp6[0] = 17'h00001; exp6[1] = 17'h00002; exp6[2] = 17'h08003;
    exp6[3] = 17'h18100; exp6[4] = 17'h18100;
`else
    exp6[0] = 17'h00001; exp6[1] = 17'h18100; exp6[2] = 17'h00002;
    exp6[3] = 17'h18100; exp6[4] = 17'h08003;
`endif
    p0 = 0; gap = 1'b0; fire0 = 1'b0;
    for (int cyc = 0; cyc < 30 && rec_q.size() < 5; cyc++) begin
      @(negedge clk);
      if (fire0) begin
        p0++;
        gap = (p0 == 1);
      end else begin
        gap = 1'b0;
      end
      c_valid[0] = (p0 < 3) && !gap;
      if (p0 < 3) c_data[0] = pkt[p0];
      c_valid[1] = 1'b1;
      c_data[1]  = 16'h8100;
      #1;
      fire0 = c_valid[0] & c_ready[0];
      if (c_out.valid) rec_q.push_back(c_out.data);
    end
    c_valid[0] = 1'b0;
    c_valid[1] = 1'b0;
    check("t6_count", rec_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("t6_beat", (i < rec_q.size()) ? 32'(rec_q[i]) : 32'hFFFF_FFFF, 32'(exp6[i]));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
